// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and the baud generator that the
// receiver will reuse later.
//   uart_state_t  : transmitter frame states
//   PARITY_*      : parity mode encodings accepted by the PARITY parameter
//   baud_period() : clock cycles per bit for a given clock and line rate
//   cnt_width()   : width of a counter that covers 0..period-1
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } uart_state_t;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  function automatic int unsigned baud_period(input int unsigned clk_hz,
                                              input int unsigned baud);
    return (baud == 0) ? 0 : clk_hz / baud;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned period);
    return (period <= 2) ? 1 : $clog2(period);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer.
//   clk       : system clock, rising edge
//   rst       : asynchronous reset, active-high
//   restart   : hold the count at 0 (next period starts the cycle after release)
//   baud_tick : high on the final cycle of each BAUD_PERIOD_CYCLES-long period
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_PERIOD_CYCLES = 1250
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic baud_tick
);

  localparam int unsigned CW = cnt_width(BAUD_PERIOD_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(BAUD_PERIOD_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign baud_tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with valid/ready input handshake.
//   clk           : system clock, rising edge
//   rst           : asynchronous reset, active-high
//   tx_data       : payload word, latched on the handshake
//   tx_data_valid : payload offered
//   tx_data_ready : block can accept (IDLE and not in reset)
//   break_req     : line-break request (only with UART_TX_BREAK_EN)
//   tx            : serial line, idle high, registered
//   transmitting  : high while a frame or break is on the line, registered
// Optional feature macro: UART_TX_BREAK_EN enables the BREAK state; without it
// break_req is an unused input.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 12000000,
  parameter int unsigned BAUD_RATE   = 9600,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY      = 0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_data_valid,
  output logic                 tx_data_ready,
  input  logic                 break_req,
  output logic                 tx,
  output logic                 transmitting
);

  localparam int unsigned BAUD_PERIOD_CYCLES = baud_period(CLK_FREQ_HZ, BAUD_RATE);

  if (BAUD_PERIOD_CYCLES < 2) begin : g_bad_baud
    $error("uart_tx_frame: CLK_FREQ_HZ/BAUD_RATE must be >= 2");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY > PARITY_ODD) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1..2");
  end

  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic       ODD_MODE  = (PARITY == PARITY_ODD);

  uart_state_t          state;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic                 baud_tick;
  logic                 restart;

  // The timer is held at zero whenever the line is not being timed by bit
  // periods, so the first period after leaving IDLE/BREAK is full length.
  assign restart = (state == ST_IDLE) || (state == ST_BREAK);

  assign tx_data_ready = !rst && (state == ST_IDLE);

  uart_baud_gen #(
    .BAUD_PERIOD_CYCLES(BAUD_PERIOD_CYCLES)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .restart  (restart),
    .baud_tick(baud_tick)
  );

`ifndef UART_TX_BREAK_EN
  logic unused_break;
  assign unused_break = break_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      tx           <= 1'b1;
      transmitting <= 1'b0;
      shreg        <= '0;
      par_bit      <= 1'b0;
      bit_idx      <= '0;
      stop_idx     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
          if (break_req) begin
            state        <= ST_BREAK;
            tx           <= 1'b0;
            transmitting <= 1'b1;
          end else
`endif
          if (tx_data_valid) begin
            shreg        <= tx_data;
            par_bit      <= (^tx_data) ^ ODD_MODE;
            state        <= ST_START;
            tx           <= 1'b0;
            transmitting <= 1'b1;
          end
        end

        ST_START: begin
          if (baud_tick) begin
            state   <= ST_DATA;
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
          end
        end

        ST_DATA: begin
          if (baud_tick) begin
            if (bit_idx == LAST_BIT) begin
              if (PARITY != PARITY_NONE) begin
                state <= ST_PARITY;
                tx    <= par_bit;
              end else begin
                state    <= ST_STOP;
                tx       <= 1'b1;
                stop_idx <= 1'b0;
              end
            end else begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end

        ST_PARITY: begin
          if (baud_tick) begin
            state    <= ST_STOP;
            tx       <= 1'b1;
            stop_idx <= 1'b0;
          end
        end

        ST_STOP: begin
          if (baud_tick) begin
            if (stop_idx == LAST_STOP) begin
              state        <= ST_IDLE;
              transmitting <= 1'b0;
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end
        end

`ifdef UART_TX_BREAK_EN
        ST_BREAK: begin
          if (!break_req) begin
            state    <= ST_STOP;
            tx       <= 1'b1;
            stop_idx <= 1'b0;
          end
        end
`endif

        default: begin
          state        <= ST_IDLE;
          tx           <= 1'b1;
          transmitting <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame. Four configurations run side by side
// on one clock (8N1, 8E2, 8O2, 5N1) plus a fifth 8N1 instance for break_req.
module tb_uart_tx_frame;

  localparam int P = 1250;  // 12 MHz / 9600

  logic       clk = 1'b0;
  logic [4:0] rst_v;
  logic [4:0] val_v;
  logic [4:0] brk_v;
  logic [8:0] d_v [0:4];
  wire  [4:0] tx_v;
  wire  [4:0] trn_v;
  wire  [4:0] rdy_v;

  always #5 clk = ~clk;

  uart_tx_frame u_8n1 (
    .clk(clk), .rst(rst_v[0]), .tx_data(d_v[0][7:0]), .tx_data_valid(val_v[0]),
    .tx_data_ready(rdy_v[0]), .break_req(brk_v[0]), .tx(tx_v[0]), .transmitting(trn_v[0]));

  uart_tx_frame #(.PARITY(1), .STOP_BITS(2)) u_8e2 (
    .clk(clk), .rst(rst_v[1]), .tx_data(d_v[1][7:0]), .tx_data_valid(val_v[1]),
    .tx_data_ready(rdy_v[1]), .break_req(brk_v[1]), .tx(tx_v[1]), .transmitting(trn_v[1]));

  uart_tx_frame #(.PARITY(2), .STOP_BITS(2)) u_8o2 (
    .clk(clk), .rst(rst_v[2]), .tx_data(d_v[2][7:0]), .tx_data_valid(val_v[2]),
    .tx_data_ready(rdy_v[2]), .break_req(brk_v[2]), .tx(tx_v[2]), .transmitting(trn_v[2]));

  uart_tx_frame #(.DATA_BITS(5)) u_5n1 (
    .clk(clk), .rst(rst_v[3]), .tx_data(d_v[3][4:0]), .tx_data_valid(val_v[3]),
    .tx_data_ready(rdy_v[3]), .break_req(brk_v[3]), .tx(tx_v[3]), .transmitting(trn_v[3]));

  uart_tx_frame u_brk (
    .clk(clk), .rst(rst_v[4]), .tx_data(d_v[4][7:0]), .tx_data_valid(val_v[4]),
    .tx_data_ready(rdy_v[4]), .break_req(brk_v[4]), .tx(tx_v[4]), .transmitting(trn_v[4]));

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: words pushed at the handshake, popped when a frame starts.
  typedef struct {
    int         inst;
    logic [8:0] word;
  } sb_t;
  sb_t sb_q[$];

  task automatic sb_push(input int inst, input logic [8:0] w);
    sb_t e;
    e.inst = inst;
    e.word = w;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input int inst, output logic [8:0] w, output bit ok);
    ok = 1'b0;
    w  = '0;
    for (int i = 0; i < sb_q.size(); i++) begin
      if (sb_q[i].inst == inst) begin
        w  = sb_q[i].word;
        ok = 1'b1;
        sb_q.delete(i);
        break;
      end
    end
  endtask

  typedef struct {
    int         inst;
    logic [8:0] data;
    int         dbits;
    int         pmode;
    int         sbits;
    logic       par;
  } vec_t;
  localparam int NV = 8;
  vec_t vecs [NV];

  // Offer one word, wait for the handshake, then scramble tx_data so a frame
  // that failed to latch its word would show it.
  task automatic send(input int inst, input logic [8:0] d);
    int n;
    n = 0;
    @(negedge clk);
    d_v[inst]   = d;
    val_v[inst] = 1'b1;
    while (!rdy_v[inst] && n < 20 * P) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("i%0d ready before send", inst), 32'(rdy_v[inst]), 1);
    @(posedge clk);
    sb_push(inst, d);
    #1;
    val_v[inst] = 1'b0;
    d_v[inst]   = ~d;
    @(negedge clk);
    check($sformatf("i%0d start latency {tx,trn}", inst), {tx_v[inst], trn_v[inst]}, 2'b01);
  endtask

  // Waits for transmitting, then checks every cycle of every bit period and
  // the idle cycle after the frame. gap = idle negedges seen before the start.
  task automatic check_frame(input int inst, input int dbits, input int pmode,
                             input int sbits, input logic exp_par, output int gap);
    logic [8:0] w;
    bit         ok;
    logic       line [0:15];
    int         nb;
    bit         tx_bad;
    bit         st_bad;
    logic       act_tx;
    logic [1:0] act_st;
    gap = 0;
    @(negedge clk);
    while (!trn_v[inst] && gap < 8 * P) begin
      gap++;
      @(negedge clk);
    end
    if (!trn_v[inst]) begin
      check($sformatf("i%0d frame start timeout", inst), 32'(trn_v[inst]), 1);
      return;
    end
    sb_pop(inst, w, ok);
    if (!ok) begin
      check($sformatf("i%0d frame without handshake", inst), 32'(ok), 1);
      return;
    end
    nb = 1 + dbits + ((pmode != 0) ? 1 : 0) + sbits;
    for (int i = 0; i < 16; i++) line[i] = 1'b1;
    line[0] = 1'b0;
    for (int i = 0; i < dbits; i++) line[1+i] = w[i];
    if (pmode != 0) line[1+dbits] = exp_par;
    for (int b = 0; b < nb; b++) begin
      tx_bad = 1'b0;
      st_bad = 1'b0;
      act_tx = 1'bx;
      act_st = 2'bxx;
      for (int c = 0; c < P; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (!tx_bad) begin
          act_tx = tx_v[inst];
          tx_bad = (act_tx !== line[b]);
        end
        if (!st_bad) begin
          act_st = {trn_v[inst], rdy_v[inst]};
          st_bad = (act_st !== 2'b10);
        end
      end
      check($sformatf("i%0d word %0h bit-period %0d tx", inst, w, b), 32'(act_tx), 32'(line[b]));
      check($sformatf("i%0d word %0h bit-period %0d {trn,rdy}", inst, w, b), 32'(act_st), 2'b10);
    end
    @(negedge clk);
    check($sformatf("i%0d word %0h end {tx,trn,rdy}", inst, w),
          {tx_v[inst], trn_v[inst], rdy_v[inst]}, 3'b101);
  endtask

  task automatic run_vectors(input int inst);
    int gap;
    for (int v = 0; v < NV; v++) begin
      if (vecs[v].inst == inst) begin
        fork
          send(inst, vecs[v].data);
          check_frame(inst, vecs[v].dbits, vecs[v].pmode, vecs[v].sbits, vecs[v].par, gap);
        join
      end
    end
  endtask

  task automatic b2b_seq();
    int gap;
    int n;
    fork
      begin
        @(negedge clk);
        d_v[0]   = 9'h055;
        val_v[0] = 1'b1;
        n = 0;
        while (!rdy_v[0] && n < 100) begin
          @(negedge clk);
          n++;
        end
        @(posedge clk);
        sb_push(0, 9'h055);
        #1;
        d_v[0] = 9'h0AA;
        @(negedge clk);
        n = 0;
        while (!rdy_v[0] && n < 20 * P) begin
          @(negedge clk);
          n++;
        end
        check("b2b second ready", 32'(rdy_v[0]), 1);
        @(posedge clk);
        sb_push(0, 9'h0AA);
        #1;
        val_v[0] = 1'b0;
        d_v[0]   = 9'h133;
      end
      begin
        check_frame(0, 8, 0, 1, 1'b0, gap);
        check_frame(0, 8, 0, 1, 1'b0, gap);
        check("b2b idle gap", gap, 0);
      end
    join
  endtask

  task automatic reset_seq();
    int gap;
    int n;
    @(negedge clk);
    d_v[0]   = 9'h048;
    val_v[0] = 1'b1;
    n = 0;
    while (!rdy_v[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    val_v[0] = 1'b0;
    repeat (4 * P + P / 2) @(negedge clk);
    check("mid data bit 3 {tx,trn}", {tx_v[0], trn_v[0]}, 2'b11);
    rst_v[0] = 1'b1;
    #1;
    check("async reset {tx,trn,rdy}", {tx_v[0], trn_v[0], rdy_v[0]}, 3'b100);
    repeat (3) @(negedge clk);
    check("held reset {tx,trn,rdy}", {tx_v[0], trn_v[0], rdy_v[0]}, 3'b100);
    rst_v[0] = 1'b0;
    #1;
    check("ready after reset", 32'(rdy_v[0]), 1);
    fork
      send(0, 9'h048);
      check_frame(0, 8, 0, 1, 1'b0, gap);
    join
  endtask

  task automatic break_seq();
    int gap;
`ifdef UART_TX_BREAK_EN
    bit         err;
    logic [2:0] act;
    @(negedge clk);
    d_v[4]   = 9'h048;
    val_v[4] = 1'b1;
    brk_v[4] = 1'b1;
    sb_push(4, 9'h048);
    err = 1'b0;
    act = 3'bxxx;
    for (int k = 0; k < 30000; k++) begin
      @(negedge clk);
      if (!err) begin
        act = {tx_v[4], trn_v[4], rdy_v[4]};
        err = (act !== 3'b010);
      end
    end
    brk_v[4] = 1'b0;
    check("break low phase {tx,trn,rdy}", 32'(act), 3'b010);
    err = 1'b0;
    act = 3'bxxx;
    for (int k = 0; k < P; k++) begin
      @(negedge clk);
      if (!err) begin
        act = {tx_v[4], trn_v[4], rdy_v[4]};
        err = (act !== 3'b110);
      end
    end
    check("break stop phase {tx,trn,rdy}", 32'(act), 3'b110);
    @(negedge clk);
    check("break idle {tx,trn,rdy}", {tx_v[4], trn_v[4], rdy_v[4]}, 3'b101);
    @(posedge clk);
    #1;
    val_v[4] = 1'b0;
    d_v[4]   = 9'h1B7;
    check_frame(4, 8, 0, 1, 1'b0, gap);
    check("break pending word gap", gap, 0);
`else
    brk_v[4] = 1'b1;
    fork
      send(4, 9'h048);
      check_frame(4, 8, 0, 1, 1'b0, gap);
    join
    brk_v[4] = 1'b0;
`endif
  endtask

  initial begin
    // parity column hand-derived: 0x48 has two ones, 0x07 three, 0x01 one
    vecs[0] = '{0, 9'h048, 8, 0, 1, 1'b0};
    vecs[1] = '{1, 9'h048, 8, 1, 2, 1'b0};
    vecs[2] = '{1, 9'h007, 8, 1, 2, 1'b1};
    vecs[3] = '{2, 9'h048, 8, 2, 2, 1'b1};
    vecs[4] = '{2, 9'h001, 8, 2, 2, 1'b0};
    vecs[5] = '{3, 9'h01F, 5, 0, 1, 1'b0};
    vecs[6] = '{3, 9'h00A, 5, 0, 1, 1'b0};
    vecs[7] = '{3, 9'h015, 5, 0, 1, 1'b0};

    rst_v = '1;
    val_v = '0;
    brk_v = '0;
    for (int i = 0; i < 5; i++) d_v[i] = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++)
      check($sformatf("i%0d reset {tx,trn,rdy}", i), {tx_v[i], trn_v[i], rdy_v[i]}, 3'b100);
    rst_v = '0;
    #1;
    for (int i = 0; i < 5; i++)
      check($sformatf("i%0d ready after release", i), 32'(rdy_v[i]), 1);

    fork
      begin
        run_vectors(0);
        b2b_seq();
        reset_seq();
      end
      run_vectors(1);
      run_vectors(2);
      run_vectors(3);
      break_seq();
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
